// File: rtl/note_sequencer_pkg.sv
// Shared definitions for the note sequencer: song ROM word layout, FSM
// state encoding and a helper that splits a ROM word into its fields.
package note_sequencer_pkg;

  localparam int META_HI = 15;
  localparam int META_LO = 13;
  localparam int NOTE_HI = 12;
  localparam int NOTE_LO = 7;
  localparam int DUR_HI  = 6;
  localparam int DUR_LO  = 1;

  localparam logic [5:0] END_MARKER_DURATION = 6'd0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    WAIT_ROM = 3'd2,
    DECODE   = 3'd3,
    PLAY     = 3'd4,
    DONE     = 3'd5
  } seq_state_e;

  typedef struct packed {
    logic [2:0] meta;
    logic [5:0] note;
    logic [5:0] dur;
  } rom_entry_t;

  // Bit 0 of the ROM word is reserved, so only [15:1] is taken here.
  function automatic rom_entry_t decode_entry(input logic [15:1] word);
    rom_entry_t e;
    e.meta = word[META_HI:META_LO];
    e.note = word[NOTE_HI:NOTE_LO];
    e.dur  = word[DUR_HI:DUR_LO];
    return e;
  endfunction

endpackage

// File: rtl/note_sequencer.sv
// Walks a song in an external synchronous ROM and hands one note at a time
// to the harmonics note player, handshaking on done_with_note.
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int SONG_BITS     = 2,
  parameter int NOTE_IDX_BITS = 5,
  parameter int BLANK_CYCLES  = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               play,
  input  logic [SONG_BITS-1:0]               song,
  input  logic                               restart,
  input  logic                               done_with_note,
  output logic [SONG_BITS+NOTE_IDX_BITS-1:0] rom_addr,
  input  logic [15:0]                        rom_data,
  output logic [5:0]                         note,
  output logic [5:0]                         duration,
  output logic [2:0]                         metadata,
  output logic                               load_new_note,
  output logic                               song_done,
  output logic [NOTE_IDX_BITS-1:0]           note_index
);

  localparam int BLANK_W = (BLANK_CYCLES < 1) ? 1 : $clog2(BLANK_CYCLES + 1);
  localparam logic [BLANK_W-1:0]       BLANK_LAST = BLANK_W'(BLANK_CYCLES);
  localparam logic [NOTE_IDX_BITS-1:0] IDX_LAST   = {NOTE_IDX_BITS{1'b1}};

  seq_state_e                 state_r, state_s;
  logic [SONG_BITS-1:0]       song_q_r, song_q_s;
  logic [NOTE_IDX_BITS-1:0]   idx_r, idx_s;
  logic [NOTE_IDX_BITS-1:0]   note_index_r, note_index_s;
  logic [BLANK_W-1:0]         blank_r, blank_s;
  logic [5:0]                 note_r, note_s;
  logic [5:0]                 duration_r, duration_s;
  logic [2:0]                 metadata_r, metadata_s;
  logic                       load_r, load_s;
  logic                       song_done_r, song_done_s;
  logic                       reseek_s;
  logic                       reserved_unused_s;
  rom_entry_t                 entry_s;

  assign entry_s           = decode_entry(rom_data[15:1]);
  assign reserved_unused_s = rom_data[0];
  assign reseek_s          = restart | (song != song_q_r);

  // Next-state and next-output logic; a reseek overrides every state.
  always_comb begin
    state_s      = state_r;
    song_q_s     = song_q_r;
    idx_s        = idx_r;
    note_index_s = note_index_r;
    blank_s      = blank_r;
    note_s       = note_r;
    duration_s   = duration_r;
    metadata_s   = metadata_r;
    load_s       = 1'b0;
    song_done_s  = song_done_r;

    if (reseek_s) begin
      state_s     = FETCH;
      song_q_s    = song;
      idx_s       = {NOTE_IDX_BITS{1'b0}};
      blank_s     = {BLANK_W{1'b0}};
      song_done_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (play) begin
            state_s = FETCH;
          end else begin
            state_s = IDLE;
          end
        end
        FETCH: begin
          if (play) begin
            state_s = WAIT_ROM;
          end else begin
            state_s = FETCH;
          end
        end
        WAIT_ROM: begin
          if (play) begin
            state_s = DECODE;
          end else begin
            state_s = WAIT_ROM;
          end
        end
        // A decode always completes, even if play has just dropped.
        DECODE: begin
          if (entry_s.dur == END_MARKER_DURATION) begin
            song_done_s = 1'b1;
            state_s     = DONE;
          end else begin
            note_s       = entry_s.note;
            duration_s   = entry_s.dur;
            metadata_s   = entry_s.meta;
            load_s       = 1'b1;
            note_index_s = idx_r;
            blank_s      = {BLANK_W{1'b0}};
            state_s      = PLAY;
          end
        end
        // Blanking hides a done_with_note left over from the previous note.
        PLAY: begin
          if (!play) begin
            state_s = PLAY;
          end else if (blank_r != BLANK_LAST) begin
            blank_s = blank_r + BLANK_W'(1);
          end else if (done_with_note) begin
            if (idx_r == IDX_LAST) begin
              song_done_s = 1'b1;
              state_s     = DONE;
            end else begin
              idx_s   = idx_r + NOTE_IDX_BITS'(1);
              state_s = FETCH;
            end
          end else begin
            state_s = PLAY;
          end
        end
        DONE: begin
          state_s = DONE;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= IDLE;
      song_q_r     <= song;
      idx_r        <= {NOTE_IDX_BITS{1'b0}};
      note_index_r <= {NOTE_IDX_BITS{1'b0}};
      blank_r      <= {BLANK_W{1'b0}};
      note_r       <= 6'd0;
      duration_r   <= 6'd0;
      metadata_r   <= 3'd0;
      load_r       <= 1'b0;
      song_done_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      song_q_r     <= song_q_s;
      idx_r        <= idx_s;
      note_index_r <= note_index_s;
      blank_r      <= blank_s;
      note_r       <= note_s;
      duration_r   <= duration_s;
      metadata_r   <= metadata_s;
      load_r       <= load_s;
      song_done_r  <= song_done_s;
    end
  end

  assign rom_addr      = {song_q_r, idx_r};
  assign note          = note_r;
  assign duration      = duration_r;
  assign metadata      = metadata_r;
  assign load_new_note = load_r;
  assign song_done     = song_done_r;
  assign note_index    = note_index_r;

endmodule
